// File: rtl/memory_bus_arbiter.sv
// Shares one single-ported memory bus between instruction fetch and data access, one
// outstanding transaction at a time. Define ARBITER_ROUND_ROBIN_EN for round-robin arbitration.
module memory_bus_arbiter #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  fetch_req,
    input  logic [ADDR_WIDTH-1:0] fetch_address,
    output logic                  fetch_ready,
    output logic                  fetch_rvalid,
    output logic [DATA_WIDTH-1:0] fetch_rdata,
    input  logic                  data_req,
    input  logic [ADDR_WIDTH-1:0] data_address,
    input  logic                  data_write_enable,
    input  logic [DATA_WIDTH-1:0] data_write_data,
    input  logic [2:0]            data_format,
    output logic                  data_ready,
    output logic                  data_rvalid,
    output logic [DATA_WIDTH-1:0] data_rdata,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_write_enable,
    output logic [DATA_WIDTH-1:0] mem_write_data,
    output logic [2:0]            mem_format,
    input  logic                  mem_ready,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [15:0]           conflict_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_DATA  = 1'b0,
        OWNER_FETCH = 1'b1
    } owner_t;

    state_t state;
    state_t state_next;
    owner_t owner;
    logic   grant_fetch;
    logic   grant_data;

    // The owner register doubles as the last-served record for round robin.
    always_comb begin
        grant_fetch = 1'b0;
        grant_data  = 1'b0;
        if (state == IDLE) begin
            if (fetch_req && data_req) begin
`ifdef ARBITER_ROUND_ROBIN_EN
                if (owner == OWNER_DATA) grant_fetch = 1'b1;
                else                     grant_data  = 1'b1;
`else
                grant_data = 1'b1;
`endif
            end else if (fetch_req) begin
                grant_fetch = 1'b1;
            end else if (data_req) begin
                grant_data = 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_fetch || grant_data) state_next = ISSUE;
            ISSUE:   if (mem_ready)  state_next = WAIT;
            WAIT:    if (mem_rvalid) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        fetch_ready  = grant_fetch;
        data_ready   = grant_data;
        mem_req      = (state == ISSUE);
        fetch_rvalid = 1'b0;
        fetch_rdata  = '0;
        data_rvalid  = 1'b0;
        data_rdata   = '0;
        if (state == WAIT && mem_rvalid) begin
            if (owner == OWNER_FETCH) begin
                fetch_rvalid = 1'b1;
                fetch_rdata  = mem_rdata;
            end else begin
                data_rvalid = 1'b1;
                data_rdata  = mem_rdata;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mem_address      <= '0;
            mem_write_enable <= 1'b0;
            mem_write_data   <= '0;
            mem_format       <= '0;
            owner            <= OWNER_DATA;
        end else if (grant_fetch) begin
            mem_address      <= fetch_address;
            mem_write_enable <= 1'b0;
            mem_write_data   <= '0;
            mem_format       <= 3'b010;
            owner            <= OWNER_FETCH;
        end else if (grant_data) begin
            mem_address      <= data_address;
            mem_write_enable <= data_write_enable;
            mem_write_data   <= data_write_data;
            mem_format       <= data_format;
            owner            <= OWNER_DATA;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            conflict_count <= '0;
        end else if (state == IDLE && fetch_req && data_req && conflict_count != '1) begin
            conflict_count <= conflict_count + 16'd1;
        end
    end

endmodule
